// File: rtl/l1c_arb_pkg.sv
// Shared types for the L1 I/D memory-port arbiter: FSM states, requester ids and
// the latched request bundle whose widths follow DATA_BITS / CACHE_TYPE_BITS.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif
`ifndef CACHE_TYPE_BITS
`define CACHE_TYPE_BITS 3
`endif

package l1c_arb_pkg;

  localparam int unsigned REQ_ADDR_W = `DATA_BITS;
  localparam int unsigned REQ_DATA_W = `DATA_BITS;
  localparam int unsigned REQ_TYPE_W = `CACHE_TYPE_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic                  write;
    logic [REQ_DATA_W-1:0] wdata;
    logic [REQ_TYPE_W-1:0] acc_type;
  } req_t;

endpackage

// File: rtl/l1c_mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to the
// requester that did not win last time.
module rr_pick2
  import l1c_arb_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e last_gnt,
  output logic    gnt_valid,
  output req_id_e gnt_id
);

  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_id    = REQ_I;
    if (i_req && d_req) begin
      if (last_gnt == REQ_I) gnt_id = REQ_D;
      else                   gnt_id = REQ_I;
    end else if (d_req) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/l1c_mem_arbiter.sv
// Shares the CPU-wrapper memory port between the L1 I and D caches.
// Define L1C_ARB_PERF_EN to build the saturating completed-transaction counters.
//
// state | meaning
// IDLE  | no grant held; round-robin pick latches the winning request
// ISSUE | first memory cycle, mem_wait ignored
// BUSY  | waiting for mem_wait low; that cycle completes the granted requester
module l1c_mem_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = REQ_ADDR_W,
  parameter int unsigned DATA_W = REQ_DATA_W,
  parameter int unsigned TYPE_W = REQ_TYPE_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_in,
  input  logic [TYPE_W-1:0] i_type,
  output logic              i_wait,
  output logic [DATA_W-1:0] i_out,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_in,
  input  logic [TYPE_W-1:0] d_type,
  output logic              d_wait,
  output logic [DATA_W-1:0] d_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_in,
  output logic [TYPE_W-1:0] mem_type,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_wait,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  arb_state_e state_q;
  req_id_e    gnt_q;
  req_id_e    last_gnt_q;
  req_id_e    pick_id;
  logic       pick_vld;
  logic       mem_req_q;
  logic       done;
  req_t       lat_q;
  req_t       i_bundle;
  req_t       d_bundle;

  rr_pick2 u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .last_gnt  (last_gnt_q),
    .gnt_valid (pick_vld),
    .gnt_id    (pick_id)
  );

  always_comb begin
    i_bundle = '{addr: REQ_ADDR_W'(i_addr), write: i_write,
                 wdata: REQ_DATA_W'(i_in), acc_type: REQ_TYPE_W'(i_type)};
    d_bundle = '{addr: REQ_ADDR_W'(d_addr), write: d_write,
                 wdata: REQ_DATA_W'(d_in), acc_type: REQ_TYPE_W'(d_type)};
  end

  assign done = (state_q == BUSY) && !mem_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_I;
      last_gnt_q <= REQ_I;
      lat_q      <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            lat_q     <= (pick_id == REQ_D) ? d_bundle : i_bundle;
            gnt_q     <= pick_id;
            mem_req_q <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: state_q <= BUSY;
        BUSY: begin
          if (!mem_wait) begin
            last_gnt_q <= gnt_q;
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // A requester that dropped req mid-grant simply sees wait low; the result is discarded.
  assign i_wait = i_req && !(done && (gnt_q == REQ_I));
  assign d_wait = d_req && !(done && (gnt_q == REQ_D));
  assign i_out  = mem_out;
  assign d_out  = mem_out;

  assign mem_req   = mem_req_q;
  assign mem_addr  = ADDR_W'(lat_q.addr);
  assign mem_write = lat_q.write;
  assign mem_in    = DATA_W'(lat_q.wdata);
  assign mem_type  = TYPE_W'(lat_q.acc_type);

`ifdef L1C_ARB_PERF_EN
  logic [CNT_W-1:0] i_cnt_q;
  logic [CNT_W-1:0] d_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
    end else if (done) begin
      if (gnt_q == REQ_I) begin
        if (i_cnt_q != '1) i_cnt_q <= i_cnt_q + CNT_W'(1);
      end else begin
        if (d_cnt_q != '1) d_cnt_q <= d_cnt_q + CNT_W'(1);
      end
    end
  end

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;
`else
  assign i_grant_cnt = '0;
  assign d_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Directed bench for l1c_mem_arbiter: round-robin order, latency, latching,
// async reset and counter saturation (CNT_W=4).
module tb_l1c_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic        i_write, d_write;
  logic [31:0] i_in, d_in;
  logic [2:0]  i_type, d_type;
  logic        i_wait, d_wait;
  logic [31:0] i_out, d_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_in;
  logic [2:0]  mem_type;
  logic [31:0] mem_out;
  logic        mem_wait;
  logic [3:0]  i_grant_cnt, d_grant_cnt;

  int checks = 0;
  int errors = 0;

`ifdef L1C_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  l1c_mem_arbiter #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_write(i_write), .i_in(i_in), .i_type(i_type),
    .i_wait(i_wait), .i_out(i_out),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_in(d_in), .d_type(d_type),
    .d_wait(d_wait), .d_out(d_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_in(mem_in),
    .mem_type(mem_type), .mem_out(mem_out), .mem_wait(mem_wait),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  initial begin
    rst = 1'b0;
    i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; i_write = 0; d_write = 0;
    i_in = 0; d_in = 0; i_type = 0; d_type = 0;
    mem_out = 32'hDEAD_BEEF; mem_wait = 1'b1;

    // reset state; wait follows req even in reset
    tick(); i_req = 1; smp();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_mem_type", mem_type, 0);
    chk("rst_i_wait", i_wait, 1);
    chk("rst_d_wait", d_wait, 0);
    chk("rst_i_cnt", i_grant_cnt, 0);

    // tie out of reset: D first, then I, then repeated tie goes to D
    tick(); i_req = 1; d_req = 1; rst = 1;
    i_addr = 32'h100; d_addr = 32'h200; mem_wait = 0;
    smp(); chk("tie_c0_mem_req", mem_req, 0);
    tick(); smp(); chk("tie_issue_req", mem_req, 1); chk("tie_first_d", mem_addr, 32'h200);
    tick(); smp(); chk("tie_d_done", d_wait, 0); chk("tie_i_waits", i_wait, 1);
    tick(); d_req = 0; smp(); chk("tie_idle_gap", mem_req, 0);
    tick(); smp(); chk("tie_i_issue", mem_req, 1); chk("tie_i_addr", mem_addr, 32'h100);
    tick(); smp(); chk("tie_i_done", i_wait, 0);
    tick(); d_req = 1; i_addr = 32'h104; d_addr = 32'h204; smp();
    tick(); smp(); chk("retie_d", mem_addr, 32'h204);
    tick(); smp(); chk("retie_d_done", d_wait, 0);
    tick(); d_req = 0; smp();
    tick(); smp(); chk("retie_i", mem_addr, 32'h104);
    tick(); smp(); chk("retie_i_done", i_wait, 0);

    // single D read, mem_wait low already in ISSUE (ignored there)
    tick(); i_req = 0; d_req = 1; d_addr = 32'h0000_1040; d_write = 0;
    smp(); chk("rd_c0_wait", d_wait, 1); chk("rd_c0_req", mem_req, 0);
    tick(); smp();
    chk("rd_c1_req", mem_req, 1); chk("rd_c1_addr", mem_addr, 32'h0000_1040);
    chk("rd_c1_wait", d_wait, 1);
    tick(); smp();
    chk("rd_c2_req", mem_req, 1); chk("rd_c2_wait", d_wait, 0);
    chk("rd_c2_dout", d_out, 32'hDEAD_BEEF); chk("rd_c2_iout", i_out, 32'hDEAD_BEEF);

    // both held continuously: I, D, I, D
    tick(); d_req = 1; i_req = 1; i_addr = 32'h300; d_addr = 32'h400;
    smp(); chk("alt_idle0", mem_req, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); smp();
      chk("alt_issue", mem_addr, (k % 2 == 1) ? 32'h400 : 32'h300);
      tick(); smp();
      chk("alt_i_wait", i_wait, (k % 2 == 1) ? 1 : 0);
      chk("alt_d_wait", d_wait, (k % 2 == 1) ? 0 : 1);
      tick();
      if (k == 3) begin i_req = 0; d_req = 0; end
      smp(); chk("alt_idle", mem_req, 0);
    end

    // D write held off 5 cycles; request fields change mid-flight
    tick(); d_req = 1; d_addr = 32'h0000_2000; d_write = 1; d_in = 32'h1234_5678;
    d_type = 3'b010; mem_wait = 1;
    smp(); chk("wr_c0_wait", d_wait, 1);
    tick(); smp(); chk("wr_c1_req", mem_req, 1); chk("wr_c1_write", mem_write, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 3) begin d_addr = 32'hFFFF_0000; d_in = 32'h0; end
      smp();
      chk("wr_busy_wait", d_wait, 1);
      chk("wr_busy_addr", mem_addr, 32'h0000_2000);
      chk("wr_busy_in", mem_in, 32'h1234_5678);
    end
    tick(); mem_wait = 0; smp();
    chk("wr_c7_done", d_wait, 0); chk("wr_c7_type", mem_type, 3'b010);
    tick(); d_req = 0; d_write = 0; smp();
    chk("wr_idle", mem_req, 0);
    chk("cnt_i_pre", i_grant_cnt, cnt_exp(4));
    chk("cnt_d_pre", d_grant_cnt, cnt_exp(6));

    // async reset during BUSY, then fresh grant of the still-pending request
    tick(); i_req = 1; i_addr = 32'h500; mem_wait = 1; smp();
    tick(); smp();
    tick(); smp(); chk("rb_busy_req", mem_req, 1);
    #1 rst = 0;
    #1;
    chk("rb_async_req", mem_req, 0);
    chk("rb_i_wait", i_wait, 1);
    chk("rb_i_cnt", i_grant_cnt, 0);
    chk("rb_d_cnt", d_grant_cnt, 0);
    chk("rb_addr", mem_addr, 0);
    tick(); rst = 1; mem_wait = 0; smp(); chk("rb_idle", mem_req, 0);
    tick(); smp(); chk("rb_regrant_req", mem_req, 1); chk("rb_regrant_addr", mem_addr, 32'h500);
    tick(); smp(); chk("rb_done", i_wait, 0);
    tick(); smp(); chk("rb_cnt1", i_grant_cnt, cnt_exp(1));

    // keep I requesting: 13 more completions (14), then 6 more (20, saturated at 15)
    repeat (13 * 3) tick();
    smp(); chk("sat_cnt14", i_grant_cnt, cnt_exp(14));
    repeat (6 * 3) tick();
    i_req = 0;
    smp();
    chk("sat_cnt15", i_grant_cnt, cnt_exp(15));
    chk("sat_d_cnt", d_grant_cnt, 0);
    chk("sat_idle", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
